// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller and the E-stage forwarding muxes.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF     = 2'b00,
        FWD_WB     = 2'b01,
        FWD_ALU_M  = 2'b10,
        FWD_LINK_M = 2'b11
    } fwd_sel_t;

    typedef enum logic {
        RUN    = 1'b0,
        LSTALL = 1'b1
    } hz_state_t;

    localparam int NUM_OPS = 2;

endpackage

// File: rtl/fwd_sel_calc.sv
// Per-operand forward select for the instruction in D; the result is registered by the caller.
module fwd_sel_calc
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic                  reg_write_e,
    input  logic                  load_e,
    input  logic                  link_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  reg_write_m,
    input  logic                  flush,
    output fwd_sel_t              sel
);

    logic hit_e;
    logic hit_m;

    assign hit_e = reg_write_e && (rd_e == rs) && (rd_e != '0);
    assign hit_m = reg_write_m && (rd_m == rs) && (rd_m != '0);

    // Youngest producer wins: the E instruction will sit in M next cycle.
    always_comb begin
        sel = FWD_RF;
        if (flush)                sel = FWD_RF;
        else if (hit_e && link_e) sel = FWD_LINK_M;
        else if (hit_e && !load_e) sel = FWD_ALU_M;
        else if (hit_m)           sel = FWD_WB;
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Load-use stall, taken-branch flush and registered forward selects for the E-stage muxes.
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic                  reg_write_e,
    input  logic                  load_e,
    input  logic                  link_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  reg_write_m,
    input  logic                  pc_src_e,
    output logic [1:0]            forward_a_e,
    output logic [1:0]            forward_b_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      fwd_cnt
`endif
);

    logic [NUM_OPS-1:0][REG_ADDR_W-1:0] rs_d;
    fwd_sel_t [NUM_OPS-1:0]             fwd_d;
    fwd_sel_t [NUM_OPS-1:0]             fwd_q;
    hz_state_t                          state_q;
    hz_state_t                          state_d;
    logic                               lu;
    logic                               bubble_e;

    assign rs_d = {rs2_d, rs1_d};

    assign lu = load_e && reg_write_e && (rd_e != '0) &&
                ((rd_e == rs1_d) || (rd_e == rs2_d)) && !pc_src_e;
    assign bubble_e = lu || pc_src_e;

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        fwd_sel_calc #(.REG_ADDR_W(REG_ADDR_W)) u_calc (
            .rs          (rs_d[i]),
            .rd_e        (rd_e),
            .reg_write_e (reg_write_e),
            .load_e      (load_e),
            .link_e      (link_e),
            .rd_m        (rd_m),
            .reg_write_m (reg_write_m),
            .flush       (bubble_e),
            .sel         (fwd_d[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OPS; i++) fwd_q[i] <= FWD_RF;
        end else begin
            fwd_q <= fwd_d;
        end
    end

    assign forward_a_e = fwd_q[0];
    assign forward_b_e = fwd_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (lu) state_d = LSTALL;
            LSTALL:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Flushes are forced high while reset is held so no garbage enters D or E.
    always_comb begin
        stall_f = lu && rst_n;
        stall_d = lu && rst_n;
        flush_d = pc_src_e || !rst_n;
        flush_e = bubble_e || !rst_n;
    end

    // E carries a bubble in LSTALL, so a fresh load-use there means upstream broke the protocol.
    a_no_lu_in_lstall: assert property (
        @(posedge clk) disable iff (!rst_n) !((state_q == LSTALL) && lu));

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] fwd_cnt_q,   fwd_cnt_d;
    logic             any_fwd;

    assign any_fwd = (fwd_d[0] != FWD_RF) || (fwd_d[1] != FWD_RF);

    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(lu);
        flush_cnt_d = flush_cnt_q + CNT_W'(pc_src_e);
        fwd_cnt_d   = fwd_cnt_q + CNT_W'(any_fwd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed vector table, reset-in-stall sequences, random run vs. a reference model.
module tb_hazard_fwd_ctrl;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] rs1_d, rs2_d, rd_e, rd_m;
    logic          reg_write_e, load_e, link_e, reg_write_m, pc_src_e;
    logic [1:0]    forward_a_e, forward_b_e;
    logic          stall_f, stall_d, flush_d, flush_e;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]   stall_cnt, flush_cnt, fwd_cnt;
    int            m_stall = 0, m_flush = 0, m_fwd = 0;
`endif

    hazard_fwd_ctrl #(.REG_ADDR_W(AW), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .rd_e        (rd_e),
        .reg_write_e (reg_write_e),
        .load_e      (load_e),
        .link_e      (link_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .pc_src_e    (pc_src_e),
        .forward_a_e (forward_a_e),
        .forward_b_e (forward_b_e),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .flush_e     (flush_e)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .fwd_cnt     (fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [AW-1:0] rs1, rs2, rde;
        logic          rwe, lde, lke;
        logic [AW-1:0] rdm;
        logic          rwm, pc;
        logic [1:0]    fa, fb;
        logic          st, fe, fd;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [AW-1:0] r1, r2, re, input logic we, ld, lk,
                         input logic [AW-1:0] rm, input logic wm, pc);
        rs1_d = r1; rs2_d = r2; rd_e = re; reg_write_e = we; load_e = ld;
        link_e = lk; rd_m = rm; reg_write_m = wm; pc_src_e = pc;
    endtask

    // Reference model: which older instruction produces the value a source register needs.
    function automatic logic m_lu();
        logic uses_load;
        uses_load = load_e && reg_write_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
        return uses_load && !pc_src_e;
    endfunction

    function automatic logic [1:0] m_sel(input logic [AW-1:0] rs);
        if (m_lu() || pc_src_e) return 2'b00;
        if (rs != 0 && reg_write_e && rd_e == rs) begin
            if (link_e)   return 2'b11;
            if (!load_e)  return 2'b10;
        end
        if (rs != 0 && reg_write_m && rd_m == rs) return 2'b01;
        return 2'b00;
    endfunction

    // One random cycle: check combinational outputs, then the registered selects after the edge.
    task automatic rand_step(inout logic prev_lu);
        logic [1:0] efa, efb;
        logic       elu;
        drive(AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
              1'($urandom), prev_lu ? 1'b0 : 1'($urandom), 1'($urandom),
              AW'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 7) == 0));
        elu = m_lu();
        efa = m_sel(rs1_d);
        efb = m_sel(rs2_d);
        #1;
        chk("rnd_stall_f", stall_f, elu);
        chk("rnd_stall_d", stall_d, elu);
        chk("rnd_flush_e", flush_e, elu || pc_src_e);
        chk("rnd_flush_d", flush_d, pc_src_e);
`ifdef HAZARD_PERF_CNT_EN
        m_stall += int'(elu);
        m_flush += int'(pc_src_e);
        m_fwd   += int'(efa != 0 || efb != 0);
`endif
        @(posedge clk); #1;
        chk("rnd_fwd_a", forward_a_e, efa);
        chk("rnd_fwd_b", forward_b_e, efb);
        prev_lu = elu;
        @(negedge clk);
    endtask

    initial begin
        logic plu;
        //          rs1 rs2 rde we ld lk rdm wm pc   fa     fb     st fe fd
        tbl[0] = '{5,  3,  5,  1, 0, 0, 0,  0, 0, 2'b10, 2'b00, 0, 0, 0};
        tbl[1] = '{2,  6,  6,  1, 1, 0, 0,  0, 0, 2'b00, 2'b00, 1, 1, 0};
        tbl[2] = '{2,  6,  0,  0, 0, 0, 6,  1, 0, 2'b00, 2'b01, 0, 0, 0};
        tbl[3] = '{1,  0,  1,  1, 0, 1, 0,  0, 0, 2'b11, 2'b00, 0, 0, 0};
        tbl[4] = '{7,  7,  7,  1, 0, 0, 7,  1, 0, 2'b10, 2'b10, 0, 0, 0};
        tbl[5] = '{0,  0,  0,  1, 0, 0, 0,  1, 0, 2'b00, 2'b00, 0, 0, 0};
        tbl[6] = '{9,  2,  9,  1, 1, 0, 0,  0, 1, 2'b00, 2'b00, 0, 1, 1};
        tbl[7] = '{4,  8,  3,  1, 0, 0, 8,  1, 0, 2'b00, 2'b01, 0, 0, 0};
        tbl[8] = '{10, 0,  10, 0, 1, 0, 10, 1, 0, 2'b01, 2'b00, 0, 0, 0};
        tbl[9] = '{5,  0,  5,  1, 0, 0, 0,  0, 1, 2'b00, 2'b00, 0, 1, 1};

        // Reset with a load-use pattern on the inputs: stalls gated, flushes forced.
        drive(5, 0, 5, 1, 1, 0, 0, 0, 0);
        #2;
        chk("rst_fwd_a", forward_a_e, 2'b00);
        chk("rst_fwd_b", forward_b_e, 2'b00);
        chk("rst_stall_f", stall_f, 1'b0);
        chk("rst_stall_d", stall_d, 1'b0);
        chk("rst_flush_d", flush_d, 1'b1);
        chk("rst_flush_e", flush_e, 1'b1);
        @(negedge clk); @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rs1, tbl[i].rs2, tbl[i].rde, tbl[i].rwe, tbl[i].lde, tbl[i].lke,
                  tbl[i].rdm, tbl[i].rwm, tbl[i].pc);
            #1;
            chk($sformatf("v%0d_stall_f", i), stall_f, tbl[i].st);
            chk($sformatf("v%0d_stall_d", i), stall_d, tbl[i].st);
            chk($sformatf("v%0d_flush_e", i), flush_e, tbl[i].fe);
            chk($sformatf("v%0d_flush_d", i), flush_d, tbl[i].fd);
            @(posedge clk); #1;
            chk($sformatf("v%0d_fwd_a", i), forward_a_e, tbl[i].fa);
            chk($sformatf("v%0d_fwd_b", i), forward_b_e, tbl[i].fb);
        end

        // Async reset clears a live non-zero select without waiting for an edge.
        @(negedge clk);
        drive(5, 0, 5, 1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("pre_rst_fwd_a", forward_a_e, 2'b10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_fwd_a", forward_a_e, 2'b00);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Reset asserted while in LSTALL, then a fresh load-use must stall normally.
        @(negedge clk);
        drive(2, 6, 6, 1, 1, 0, 0, 0, 0);
        #1;
        chk("ls_stall_f", stall_f, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ls_rst_fwd_a", forward_a_e, 2'b00);
        chk("ls_rst_fwd_b", forward_b_e, 2'b00);
        chk("ls_rst_flush_d", flush_d, 1'b1);
        chk("ls_rst_flush_e", flush_e, 1'b1);
        chk("ls_rst_stall_f", stall_f, 1'b0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        chk("ls_rel_stall_f", stall_f, 1'b0);
        chk("ls_rel_flush_e", flush_e, 1'b0);
        @(negedge clk);
        drive(3, 1, 3, 1, 1, 0, 0, 0, 0);
        #1;
        chk("ls_again_stall_d", stall_d, 1'b1);
        @(negedge clk);
        drive(3, 1, 0, 0, 0, 0, 3, 1, 0);
        #1;
        chk("ls_after_stall_f", stall_f, 1'b0);
        @(posedge clk); #1;
        chk("ls_after_fwd_a", forward_a_e, 2'b01);

        // Fresh reset so the optional counters start from zero for the random run.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        plu = 1'b0;
        for (int c = 0; c < 3000; c++) rand_step(plu);

`ifdef HAZARD_PERF_CNT_EN
        chk("cnt_stall", stall_cnt, 32'(m_stall));
        chk("cnt_flush", flush_cnt, 32'(m_flush));
        chk("cnt_fwd", fwd_cnt, 32'(m_fwd));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage RV32I pipeline.
- Sits directly upstream of the E-stage operand and branch-source forwarding muxes. It drives their 2-bit select inputs, whose encoding it defines: 00 = register-file value, 01 = W-stage result, 10 = M-stage ALU result, 11 = M-stage link value (PC+4).
- Forward selects are computed one cycle early, from D-stage operands, and registered, so the E-stage mux select path starts at a flop.
- Also generates load-use stalls and taken-branch flushes.

Parameters:
REG_ADDR_W, 5, register address width
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
rs1_d  input  REG_ADDR_W  D-stage source 1
rs2_d  input  REG_ADDR_W  D-stage source 2
rd_e  input  REG_ADDR_W  E-stage destination
reg_write_e  input  1  E-stage writes rd
load_e  input  1  E-stage instruction is a load
link_e  input  1  E-stage instruction is JAL/JALR (rd gets PC+4)
rd_m  input  REG_ADDR_W  M-stage destination
reg_write_m  input  1  M-stage writes rd
pc_src_e  input  1  branch/jump taken, resolved in E
forward_a_e  output  2  select for operand A / branch source 1 mux
forward_b_e  output  2  select for operand B / branch source 2 mux
stall_f  output  1  hold PC
stall_d  output  1  hold F/D register
flush_d  output  1  clear F/D register
flush_e  output  1  clear D/E register (bubble)

Behaviour:
- Register file is write-first: a W-stage write is visible to a D-stage read in the same cycle. No D-stage forwarding from W is needed.
- Destination x0 never matches. Any rd equal to 0 is treated as no hazard and no forward.
- Load-use hazard (combinational): load_e & reg_write_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d).
  - lu = hazard & ~pc_src_e.
  - stall_f = stall_d = lu.
  - flush_e = lu | pc_src_e.
  - flush_d = pc_src_e.
  - A taken branch always beats a load stall.
- Forward-select registers update on every rising edge. Per operand (shown for A, B identical with rs2_d), the next value is:
  - 00 if flush_e is asserted (bubble entering E);
  - else 11 if reg_write_e & link_e & rd_e==rs1_d & rd_e!=0;
  - else 10 if reg_write_e & ~load_e & rd_e==rs1_d & rd_e!=0;
  - else 01 if reg_write_m & rd_m==rs1_d & rd_m!=0 (the M instruction will be in W when this one is in E);
  - else 00.
  - Priority: the youngest producer (E) wins over M.
- Select latency: exactly one cycle. The select presented with an instruction in E was computed while it was in D.
- FSM, 2 states:
  - RUN → LSTALL when lu=1.
  - LSTALL → RUN unconditionally after 1 cycle.
  - In LSTALL, lu is guaranteed 0 because E holds a bubble. An assertion flags lu=1 in LSTALL as a protocol error.
  - The state is exported only internally and to the counters.
- Reset (rst_n=0, asynchronous):
  - forward_a_e = forward_b_e = 00, state = RUN.
  - stall_f = stall_d = 0.
  - flush_d = flush_e = 1 while reset is held.
- Reset deasserting mid-stall returns cleanly to RUN with no residual stall.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds three output ports, each CNT_W bits wide and reset to 0:
  - stall_cnt: +1 per cycle with lu=1.
  - flush_cnt: +1 per cycle with pc_src_e=1.
  - fwd_cnt: +1 per cycle with either next select != 00.
  - All counters wrap at 2^CNT_W.
- When undefined, the ports and logic are absent and the block behaves identically otherwise.

Decomposition:
- Package hazard_pkg holds:
  - typedef fwd_sel_t (2-bit enum FWD_RF=00, FWD_WB=01, FWD_ALU_M=10, FWD_LINK_M=11);
  - typedef hz_state_t (RUN, LSTALL).
- The forwarding muxes import fwd_sel_t from the same package.
- One sub-module, fwd_sel_calc: a pure combinational per-operand select computation, instantiated twice (rs1_d, rs2_d).

Test Plan:
- add x5 in E, rs1_d=5 → next cycle forward_a_e=10, forward_b_e=00, no stall.
- lw x6 in E (load_e=1), rs2_d=6 → stall_f=stall_d=flush_e=1 for one cycle; following cycle forward_b_e=01 and stalls cleared.
- jal x1 in E, rs1_d=1 → forward_a_e=11 next cycle.
- rd_e=rd_m=7, both writing, rs1_d=7 → forward_a_e=10 (E beats M); with rd_e=0, rs1_d=0 → 00.
- Load-use and pc_src_e=1 in the same cycle → stall_f=0, flush_d=flush_e=1, selects 00 next cycle.
- rst_n pulled low during LSTALL → selects 00 immediately, flushes 1; after release state=RUN, no stall.
